// File: rtl/flag_branch_unit_if.sv
// ALU-status / branch-resolution bundle between the EX/ID stages and the flag branch unit.
// master drives the pipeline side, slave is the flag branch unit itself.
interface flag_branch_if #(
    parameter int WIDTH = 16
);
    logic             stall;
    logic             alu_valid;
    logic [2:0]       flag_we;
    logic [WIDTH-1:0] alu_result;
    logic             alu_ovfl;
    logic             alu_neg;
    logic             br_valid;
    logic [2:0]       br_cond;
    logic [2:0]       flags_out;
    logic             br_taken;
    logic             flush;
    logic             br_not_taken;

    modport master (
        output stall, alu_valid, flag_we, alu_result, alu_ovfl, alu_neg,
        output br_valid, br_cond,
        input  flags_out, br_taken, flush, br_not_taken
    );

    modport slave (
        input  stall, alu_valid, flag_we, alu_result, alu_ovfl, alu_neg,
        input  br_valid, br_cond,
        output flags_out, br_taken, flush, br_not_taken
    );
endinterface

// File: rtl/flag_branch_unit.sv
// Architectural N/V/Z flag register plus conditional-branch resolver.
// Flags written by the instruction in EX are bypassed to the branch in ID.
module flag_branch_unit #(
    parameter int WIDTH = 16
) (
    input logic         clk,
    input logic         rst_n,
    flag_branch_if.slave bus
);
    localparam int N_BIT = 2;
    localparam int V_BIT = 1;
    localparam int Z_BIT = 0;

    typedef enum logic [2:0] {
        COND_NE     = 3'b000,
        COND_EQ     = 3'b001,
        COND_GT     = 3'b010,
        COND_LT     = 3'b011,
        COND_GE     = 3'b100,
        COND_LE     = 3'b101,
        COND_OV     = 3'b110,
        COND_ALWAYS = 3'b111
    } cond_e;

    logic [WIDTH-1:0] result;
    logic [2:0]       flags_q, flags_d;
    logic [2:0]       flags_new, flags_eff, wr_mask;
    logic             wr, res, cond_true;
    logic             eff_n, eff_v, eff_z;
    logic             br_taken_q, br_taken_d;
    logic             br_not_taken_q, br_not_taken_d;
    logic             flush_q, flush_d;

    assign result = bus.alu_result;

    // Bits not being written this cycle fall through to the register, so a
    // partial write (e.g. Z only) still lets the branch see stored N/V.
    always_comb begin
        wr        = bus.alu_valid & ~bus.stall;
        flags_new = {bus.alu_neg, bus.alu_ovfl, (result == '0)};
        wr_mask   = bus.flag_we & {3{wr}};
        flags_eff = (wr_mask & flags_new) | (~wr_mask & flags_q);
        flags_d   = flags_eff;
        eff_n     = flags_eff[N_BIT];
        eff_v     = flags_eff[V_BIT];
        eff_z     = flags_eff[Z_BIT];
    end

    always_comb begin
        cond_true = 1'b0;
        case (cond_e'(bus.br_cond))
            COND_NE:     cond_true = ~eff_z;
            COND_EQ:     cond_true = eff_z;
            COND_GT:     cond_true = ~eff_z & ~eff_n;
            COND_LT:     cond_true = eff_n;
            COND_GE:     cond_true = eff_z | ~eff_n;
            COND_LE:     cond_true = eff_n | eff_z;
            COND_OV:     cond_true = eff_v;
            COND_ALWAYS: cond_true = 1'b1;
            default:     cond_true = 1'b0;
        endcase
    end

    // A stalled branch simply does not resolve; it resolves once ID is released.
    always_comb begin
        res            = bus.br_valid & ~bus.stall;
        br_taken_d     = res & cond_true;
        br_not_taken_d = res & ~cond_true;
        flush_d        = res & cond_true;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags_q        <= 3'b000;
            br_taken_q     <= 1'b0;
            br_not_taken_q <= 1'b0;
            flush_q        <= 1'b0;
        end else begin
            flags_q        <= flags_d;
            br_taken_q     <= br_taken_d;
            br_not_taken_q <= br_not_taken_d;
            flush_q        <= flush_d;
        end
    end

    assign bus.flags_out    = flags_q;
    assign bus.br_taken     = br_taken_q;
    assign bus.br_not_taken = br_not_taken_q;
    assign bus.flush        = flush_q;
endmodule

// File: tb/tb_flag_branch_unit.sv
// Directed vector table for the flag branch unit followed by a randomized run
// checked against a flag/branch reference model.
module tb_flag_branch_unit;
    localparam int WIDTH = 16;
    localparam int NVEC  = 24;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    flag_branch_if #(.WIDTH(WIDTH)) bus ();

    flag_branch_unit #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        rst_n;
        logic        stall;
        logic        alu_valid;
        logic [2:0]  we;
        logic [15:0] result;
        logic        ovfl;
        logic        neg;
        logic        br_valid;
        logic [2:0]  cond;
        logic [2:0]  exp_flags;
        logic        exp_taken;
        logic        exp_nt;
    } vec_t;

    vec_t tbl [NVEC];
    int   checks   = 0;
    int   failures = 0;

    // Reference state: one entry per flag, named rather than packed.
    bit   ref_n, ref_v, ref_z;
    bit   ref_taken, ref_nt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic st, input logic av, input logic [2:0] we,
                         input logic [15:0] res, input logic ov, input logic ng,
                         input logic bv, input logic [2:0] cd);
        rst_n          = r;
        bus.stall      = st;
        bus.alu_valid  = av;
        bus.flag_we    = we;
        bus.alu_result = res;
        bus.alu_ovfl   = ov;
        bus.alu_neg    = ng;
        bus.br_valid   = bv;
        bus.br_cond    = cd;
    endtask

    function automatic bit branch_goes(input bit n, input bit v, input bit z, input logic [2:0] cd);
        case (cd)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || !n;
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    // Advances the reference model by one clock using the currently driven inputs.
    task automatic model_step();
        bit commit, n_now, v_now, z_now, go;
        commit = bus.alu_valid && !bus.stall;
        n_now  = (commit && bus.flag_we[2]) ? bus.alu_neg         : ref_n;
        v_now  = (commit && bus.flag_we[1]) ? bus.alu_ovfl        : ref_v;
        z_now  = (commit && bus.flag_we[0]) ? (bus.alu_result == 0) : ref_z;
        go     = branch_goes(n_now, v_now, z_now, bus.br_cond);
        if (!rst_n) begin
            {ref_n, ref_v, ref_z} = 3'b000;
            ref_taken = 0;
            ref_nt    = 0;
        end else begin
            {ref_n, ref_v, ref_z} = {n_now, v_now, z_now};
            ref_taken = bus.br_valid && !bus.stall && go;
            ref_nt    = bus.br_valid && !bus.stall && !go;
        end
    endtask

    initial begin
        //            rst st av we      result    ov ng bv cond    flags   tk nt
        tbl[0]  = '{0, 0, 0, 3'b000, 16'h0000, 0, 0, 0, 3'd0, 3'b000, 0, 0};
        tbl[1]  = '{1, 0, 0, 3'b000, 16'h0000, 0, 0, 0, 3'd0, 3'b000, 0, 0};
        tbl[2]  = '{1, 0, 0, 3'b000, 16'h0000, 0, 0, 0, 3'd0, 3'b000, 0, 0};
        tbl[3]  = '{1, 0, 0, 3'b000, 16'h0000, 0, 0, 0, 3'd0, 3'b000, 0, 0};
        tbl[4]  = '{1, 0, 0, 3'b000, 16'h0000, 0, 0, 0, 3'd0, 3'b000, 0, 0};
        tbl[5]  = '{1, 0, 0, 3'b000, 16'h0000, 0, 0, 0, 3'd0, 3'b000, 0, 0};
        tbl[6]  = '{1, 0, 1, 3'b111, 16'h7FFF, 1, 0, 1, 3'd6, 3'b010, 1, 0}; // ADD sat + OV branch
        tbl[7]  = '{1, 0, 1, 3'b111, 16'h0000, 0, 0, 0, 3'd0, 3'b001, 0, 0}; // SUB -> zero
        tbl[8]  = '{1, 0, 1, 3'b001, 16'h0005, 0, 0, 1, 3'd1, 3'b000, 0, 1}; // XOR, EQ sees bypassed Z=0
        tbl[9]  = '{1, 0, 1, 3'b111, 16'h8000, 0, 1, 0, 3'd0, 3'b100, 0, 0}; // N=1
        tbl[10] = '{1, 1, 0, 3'b000, 16'h0000, 0, 0, 1, 3'd3, 3'b100, 0, 0}; // LT held under stall
        tbl[11] = '{1, 1, 0, 3'b000, 16'h0000, 0, 0, 1, 3'd3, 3'b100, 0, 0};
        tbl[12] = '{1, 1, 0, 3'b000, 16'h0000, 0, 0, 1, 3'd3, 3'b100, 0, 0};
        tbl[13] = '{1, 0, 0, 3'b000, 16'h0000, 0, 0, 1, 3'd3, 3'b100, 1, 0}; // resolves once
        tbl[14] = '{1, 0, 0, 3'b000, 16'h0000, 0, 0, 0, 3'd3, 3'b100, 0, 0};
        tbl[15] = '{0, 0, 0, 3'b000, 16'h0000, 0, 0, 0, 3'd0, 3'b000, 0, 0};
        tbl[16] = '{1, 0, 0, 3'b111, 16'h0000, 0, 0, 1, 3'd1, 3'b000, 0, 1}; // bubble: no write/bypass
        tbl[17] = '{1, 0, 1, 3'b111, 16'h8000, 1, 1, 0, 3'd0, 3'b110, 0, 0}; // flags=110
        tbl[18] = '{0, 0, 1, 3'b111, 16'h0000, 0, 0, 1, 3'd6, 3'b000, 0, 0}; // reset beats taken branch
        tbl[19] = '{1, 0, 0, 3'b000, 16'h0000, 0, 0, 0, 3'd0, 3'b000, 0, 0};
        tbl[20] = '{1, 1, 1, 3'b111, 16'h0000, 1, 1, 1, 3'd7, 3'b000, 0, 0}; // stall blocks write+branch
        tbl[21] = '{1, 0, 0, 3'b000, 16'h0000, 0, 0, 1, 3'd7, 3'b000, 1, 0};
        tbl[22] = '{1, 0, 1, 3'b111, 16'hFFFF, 0, 1, 0, 3'd0, 3'b100, 0, 0};
        tbl[23] = '{1, 0, 1, 3'b001, 16'h0000, 1, 0, 1, 3'd5, 3'b101, 1, 0}; // LE: N reg, Z bypass

        drive(0, 0, 0, 3'b000, 16'h0000, 0, 0, 0, 3'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < NVEC; i++) begin
            drive(tbl[i].rst_n, tbl[i].stall, tbl[i].alu_valid, tbl[i].we, tbl[i].result,
                  tbl[i].ovfl, tbl[i].neg, tbl[i].br_valid, tbl[i].cond);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d flags_out", i), {29'd0, bus.flags_out}, {29'd0, tbl[i].exp_flags});
            chk($sformatf("vec%0d br_taken", i), {31'd0, bus.br_taken}, {31'd0, tbl[i].exp_taken});
            chk($sformatf("vec%0d flush", i), {31'd0, bus.flush}, {31'd0, tbl[i].exp_taken});
            chk($sformatf("vec%0d br_not_taken", i), {31'd0, bus.br_not_taken}, {31'd0, tbl[i].exp_nt});
        end

        // Random phase starts from a known reset on both sides.
        drive(0, 0, 0, 3'b000, 16'h0000, 0, 0, 0, 3'd0);
        model_step();
        @(posedge clk);
        #1;

        for (int i = 0; i < 400; i++) begin
            logic [15:0] r;
            r = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            drive(($urandom_range(0, 29) != 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 3) != 0), 3'($urandom), r,
                  1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom));
            model_step();
            @(posedge clk);
            #1;
            chk($sformatf("rnd%0d flags_out", i), {29'd0, bus.flags_out}, {29'd0, ref_n, ref_v, ref_z});
            chk($sformatf("rnd%0d br_taken", i), {31'd0, bus.br_taken}, {31'd0, ref_taken});
            chk($sformatf("rnd%0d flush", i), {31'd0, bus.flush}, {31'd0, ref_taken});
            chk($sformatf("rnd%0d br_not_taken", i), {31'd0, bus.br_not_taken}, {31'd0, ref_nt});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/flag_branch_unit.md
Name: flag_branch_unit

Overview:
- Consumer side of the ALU status interface. Holds the architectural N/V/Z flag register, which is loaded from the saturating add/sub result and its overflow/negative outputs.
- Resolves conditional branches in ID against those flags.
- Flags being written by the instruction currently in EX are bypassed to the branch in ID, so a branch right after a flag-setter needs no stall.
- Produces a registered one-cycle branch-taken/flush pulse for fetch and pipeline control.

Parameters:
WIDTH, 16, ALU result width used for the zero detect.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
stall  input  1  pipeline stall; freezes flags and blocks resolution
alu_valid  input  1  EX holds a real instruction (not a bubble)
flag_we  input  3  per-flag write enable {N,V,Z} from decode (ADD/SUB=111, XOR/SLL/SRA/ROR=001, others=000)
alu_result  input  WIDTH  final (saturated) ALU result
alu_ovfl  input  1  ALU overflow flag
alu_neg  input  1  ALU negative flag (sign of saturated result)
br_valid  input  1  ID holds a conditional branch (B or BR)
br_cond  input  3  condition code
flags_out  output  3  registered {N,V,Z}
br_taken  output  1  registered: branch resolved taken last cycle
flush  output  1  registered: kill IF/ID, equals br_taken
br_not_taken  output  1  registered: branch resolved not taken last cycle

Behaviour:
- Reset (rst_n=0 at a rising edge): flags_out=3'b000, br_taken=0, flush=0, br_not_taken=0. Reset overrides all other inputs, including mid-stall or mid-branch.
- Zero detect: z_new = (alu_result == 0). n_new = alu_neg. v_new = alu_ovfl.
- Flag write condition: wr = alu_valid & ~stall.
  - When wr is true, each flag bit with its flag_we bit set loads its new value at the edge.
  - Bits with we=0 hold their value.
- Bypass: eff_X = (wr & flag_we[X]) ? X_new : flag_reg_X, evaluated combinationally for each flag.
- Condition evaluation on eff flags:
  - 000 NE: Z=0
  - 001 EQ: Z=1
  - 010 GT: Z=0 & N=0
  - 011 LT: N=1
  - 100 GE: Z=1 | (Z=0 & N=0)
  - 101 LE: N=1 | Z=1
  - 110 OV: V=1
  - 111 always
- Resolution: res = br_valid & ~stall. At the edge:
  - br_taken <= res & cond_true
  - br_not_taken <= res & ~cond_true
  - flush <= res & cond_true
- Latency: flags visible on flags_out 1 cycle after the write. Branch outcome is visible 1 cycle after the cycle in which br_valid & ~stall.
- br_taken and br_not_taken are mutually exclusive single-cycle pulses per resolution. A branch held in ID under stall resolves exactly once, in the first non-stalled cycle.
- Stall cycle: flags hold; br_taken, br_not_taken and flush are 0 on the next cycle.
- alu_valid=0 (bubble): no flag write, no bypass.
- Simultaneous flag write and branch: the branch uses the bypassed new values; the register also updates.
- Partial write (we=001) with a branch: N and V come from the register, Z from the bypass.
- No internal state other than the 3 flag bits and 3 output registers; the unit has no memory of past branches.

Test Plan:
- Reset then idle -> flags_out=000, br_taken=0, flush=0, br_not_taken=0 for 5 cycles.
- ADD with alu_valid=1, we=111, result=16'h7FFF, ovfl=1, neg=0; same cycle br_valid, cond=110 -> next cycle br_taken=1, flush=1, flags_out=010.
- SUB result=0, we=111, then XOR result=16'h0005, we=001 with branch cond=001 in the same cycle -> br_not_taken=1; flags_out goes 001 then 000.
- Branch cond=011 with stall=1 for 3 cycles while N=1, then stall=0 -> no pulse during the stall; exactly one br_taken pulse 1 cycle after the stall drops.
- alu_valid=0 with we=111, result=0, plus branch cond=001 on reset flags -> no flag change, br_not_taken=1.
- Assert rst_n=0 in the same cycle as a taken branch with flags=110 -> next cycle all outputs 0, flags_out=000.
